// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared encodings for the SPI command sequencer: FSM states and register offsets on both
// the host-side and core-side settings buses.
package spi_cmd_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWrDiv    = 3'd1,
    StWrCfg    = 3'd2,
    StWrData   = 3'd3,
    StGuard    = 3'd4,
    StWaitDone = 3'd5,
    StRbHold   = 3'd6
  } state_e;

  localparam int unsigned HostDivOff    = 0;
  localparam int unsigned HostCfgOff    = 1;
  localparam int unsigned HostPushOff   = 2;
  localparam int unsigned HostOvfClrOff = 3;

  localparam int unsigned CoreDivOff  = 0;
  localparam int unsigned CoreCfgOff  = 1;
  localparam int unsigned CoreDataOff = 2;

  localparam int unsigned CmdWidth = 64;

  function automatic logic [7:0] reg_addr(input int unsigned base, input int unsigned off);
    return 8'(base + off);
  endfunction

endpackage

// File: rtl/spi_cmd_sequencer_fifo.sv
// Synchronous FIFO holding queued {config, data} commands; the head is readable
// combinationally so a pop and the capture of its word happen in the same cycle.
module spi_cmd_sequencer_fifo #(
  parameter int unsigned Width     = 64,
  parameter int unsigned DepthLog2 = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [Width-1:0]     wr_data,
  input  logic                 pop,
  output logic [Width-1:0]     rd_data,
  output logic                 full,
  output logic                 empty,
  output logic [DepthLog2:0]   count
);

  localparam int unsigned Depth = 2 ** DepthLog2;

  logic [Width-1:0]     mem_q [Depth];
  logic [DepthLog2-1:0] wr_ptr_q, rd_ptr_q;
  logic [DepthLog2:0]   count_q;
  logic                 push_ok, pop_ok;

  // Occupancy never exceeds Depth, so the top bit alone marks full.
  assign full    = count_q[DepthLog2];
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Queues host SPI transactions and replays each one to the SPI core's settings bus
// (divider, config, data), then returns the core's readback over a valid/ready port.
module spi_cmd_sequencer
  import spi_cmd_sequencer_pkg::*;
#(
  parameter int unsigned BASE       = 0,
  parameter int unsigned SPI_BASE   = 8,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_stb,
  input  logic [7:0]            set_addr,
  input  logic [31:0]           set_data,
  output logic                  spi_set_stb,
  output logic [7:0]            spi_set_addr,
  output logic [31:0]           spi_set_data,
  input  logic                  spi_ready,
  input  logic [31:0]           spi_readback,
  output logic [31:0]           rb_data,
  output logic                  rb_valid,
  input  logic                  rb_ready,
  output logic [DEPTH_LOG2:0]   cmd_count,
  output logic                  overflow,
  output logic                  busy
);

  state_e                state_q, state_d;
  logic [15:0]           divider_q;
  logic [31:0]           cfg_hold_q;
  logic                  overflow_q;
  logic [CmdWidth-1:0]   cmd_q, cmd_d;
  logic                  guard_cnt_q, guard_cnt_d;
  logic [31:0]           rb_data_q, rb_data_d;
  logic                  rb_valid_q, rb_valid_d;
  logic                  stb_q, stb_d;
  logic [7:0]            addr_q, addr_d;
  logic [31:0]           data_q, data_d;

  logic                  wr_div, wr_cfg, wr_push, wr_clr;
  logic                  fifo_pop, fifo_full, fifo_empty;
  logic [CmdWidth-1:0]   fifo_head;

  assign wr_div  = set_stb && (set_addr == reg_addr(BASE, HostDivOff));
  assign wr_cfg  = set_stb && (set_addr == reg_addr(BASE, HostCfgOff));
  assign wr_push = set_stb && (set_addr == reg_addr(BASE, HostPushOff));
  assign wr_clr  = set_stb && (set_addr == reg_addr(BASE, HostOvfClrOff));

  spi_cmd_sequencer_fifo #(
    .Width     (CmdWidth),
    .DepthLog2 (DEPTH_LOG2)
  ) u_cmd_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (wr_push),
    .wr_data ({cfg_hold_q, set_data}),
    .pop     (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (cmd_count)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      divider_q  <= '0;
      cfg_hold_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_div) divider_q  <= set_data[15:0];
      if (wr_cfg) cfg_hold_q <= set_data;
      if (wr_push && fifo_full) overflow_q <= 1'b1;
      else if (wr_clr)          overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      cmd_q       <= '0;
      guard_cnt_q <= 1'b0;
      rb_data_q   <= '0;
      rb_valid_q  <= 1'b0;
      stb_q       <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      guard_cnt_q <= guard_cnt_d;
      rb_data_q   <= rb_data_d;
      rb_valid_q  <= rb_valid_d;
      stb_q       <= stb_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    fifo_pop    = 1'b0;
    cmd_d       = cmd_q;
    guard_cnt_d = 1'b0;
    rb_data_d   = rb_data_q;
    rb_valid_d  = rb_valid_q;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          cmd_d    = fifo_head;
          state_d  = StWrDiv;
        end
      end
      StWrDiv:  state_d = StWrCfg;
      StWrCfg:  state_d = StWrData;
      StWrData: state_d = StGuard;
      // Two dead cycles while the core's ready line catches up with the trigger.
      StGuard: begin
        guard_cnt_d = ~guard_cnt_q;
        if (guard_cnt_q) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (spi_ready) begin
          rb_data_d  = spi_readback;
          rb_valid_d = 1'b1;
          state_d    = StRbHold;
        end
      end
      StRbHold: begin
        if (rb_valid_q && rb_ready) begin
          rb_valid_d = 1'b0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Core-bus outputs are decoded from the next state so they register alongside it.
  always_comb begin
    stb_d  = 1'b0;
    addr_d = '0;
    data_d = '0;
    unique case (state_d)
      StWrDiv: begin
        stb_d  = 1'b1;
        addr_d = reg_addr(SPI_BASE, CoreDivOff);
        data_d = {16'h0000, divider_q};
      end
      StWrCfg: begin
        stb_d  = 1'b1;
        addr_d = reg_addr(SPI_BASE, CoreCfgOff);
        data_d = cmd_q[63:32];
      end
      StWrData: begin
        stb_d  = 1'b1;
        addr_d = reg_addr(SPI_BASE, CoreDataOff);
        data_d = cmd_q[31:0];
      end
      default: ;
    endcase
  end

  assign spi_set_stb  = stb_q;
  assign spi_set_addr = addr_q;
  assign spi_set_data = data_q;
  assign rb_data      = rb_data_q;
  assign rb_valid     = rb_valid_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Bench for spi_cmd_sequencer: behavioural SPI core model plus a scoreboard of expected
// core-bus strobes and readbacks, driven from a vector table and directed sequences.
module tb_spi_cmd_sequencer;

  localparam int unsigned Base      = 0;
  localparam int unsigned SpiBase   = 8;
  localparam int unsigned DepthLog2 = 4;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                 reset, set_stb, spi_ready, rb_ready;
  logic [7:0]           set_addr;
  logic [31:0]          set_data, spi_readback;
  logic                 spi_set_stb, rb_valid, overflow, busy;
  logic [7:0]           spi_set_addr;
  logic [31:0]          spi_set_data, rb_data;
  logic [DepthLog2:0]   cmd_count;

  spi_cmd_sequencer #(
    .BASE       (Base),
    .SPI_BASE   (SpiBase),
    .DEPTH_LOG2 (DepthLog2)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .set_stb      (set_stb),
    .set_addr     (set_addr),
    .set_data     (set_data),
    .spi_set_stb  (spi_set_stb),
    .spi_set_addr (spi_set_addr),
    .spi_set_data (spi_set_data),
    .spi_ready    (spi_ready),
    .spi_readback (spi_readback),
    .rb_data      (rb_data),
    .rb_valid     (rb_valid),
    .rb_ready     (rb_ready),
    .cmd_count    (cmd_count),
    .overflow     (overflow),
    .busy         (busy)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } stb_t;

  typedef struct {
    logic [15:0] div;
    logic [31:0] cfg;
    logic [31:0] data;
    int          lat;
    logic [31:0] rb;
  } vec_t;

  stb_t        exp_stb[$];
  logic [31:0] exp_rb[$];
  vec_t        vecs[4];

  int          checks = 0;
  int          failures = 0;
  int          cycle = 0;
  int          last_stb_cycle = -10;
  bit          inflight = 1'b0;
  int          core_cnt = 0;
  int          core_lat = 3;
  logic [15:0] m_div = '0;
  logic [31:0] m_cfg = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic fail(input string name, input int got, input int want);
    checks++;
    failures++;
    $display("FAIL %s: got %0d expected %0d", name, got, want);
  endtask

  // One clock: scoreboard the strobe / handshake that just happened, then step the core model.
  task automatic tick();
    bit          hs;
    logic [31:0] snap;
    stb_t        e;
    hs   = rb_valid && rb_ready;
    snap = rb_data;
    @(negedge clock);
    cycle++;
    if (hs) begin
      if (exp_rb.size() == 0) fail("unexpected_rb", 1, 0);
      else check("rb_data", {32'h0, snap}, {32'h0, exp_rb.pop_front()});
      inflight = 1'b0;
    end
    if (spi_set_stb) begin
      if (exp_stb.size() == 0) begin
        fail("unexpected_stb_addr", int'(spi_set_addr), -1);
      end else begin
        e = exp_stb.pop_front();
        check("stb_addr", {56'h0, spi_set_addr}, {56'h0, e.addr});
        check("stb_data", {32'h0, spi_set_data}, {32'h0, e.data});
        if (spi_set_addr == 8'(SpiBase)) begin
          check("one_in_flight", {63'h0, inflight}, 64'h0);
          inflight = 1'b1;
        end else begin
          check("stb_consecutive", 64'(cycle), 64'(last_stb_cycle + 1));
        end
        last_stb_cycle = cycle;
      end
    end
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) spi_ready = 1'b1;
    end
    if (spi_set_stb && spi_set_addr == 8'(SpiBase + 2)) begin
      spi_ready    = 1'b0;
      core_cnt     = core_lat;
      spi_readback = ~spi_set_data;
    end
  endtask

  task automatic host_write(input logic [7:0] addr, input logic [31:0] data);
    set_stb  = 1'b1;
    set_addr = addr;
    set_data = data;
    tick();
    set_stb  = 1'b0;
  endtask

  task automatic wr_div(input logic [15:0] d);
    m_div = d;
    host_write(8'(Base + 0), {16'h0, d});
  endtask

  task automatic wr_cfg(input logic [31:0] c);
    m_cfg = c;
    host_write(8'(Base + 1), c);
  endtask

  task automatic push(input logic [31:0] data, input bit accept, input logic [31:0] rb);
    stb_t e;
    if (accept) begin
      e.addr = 8'(SpiBase);     e.data = {16'h0, m_div}; exp_stb.push_back(e);
      e.addr = 8'(SpiBase + 1); e.data = m_cfg;          exp_stb.push_back(e);
      e.addr = 8'(SpiBase + 2); e.data = data;           exp_stb.push_back(e);
      exp_rb.push_back(rb);
    end
    host_write(8'(Base + 2), data);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_stb.size() != 0 || exp_rb.size() != 0) && n < bound) begin
      tick();
      n++;
    end
    if (exp_stb.size() != 0 || exp_rb.size() != 0)
      fail("drain_timeout_pending", exp_stb.size() + exp_rb.size(), 0);
  endtask

  task automatic wait_rb_valid(input int bound);
    int n = 0;
    while (!rb_valid && n < bound) begin
      tick();
      n++;
    end
    if (!rb_valid) fail("rb_valid_timeout", 0, 1);
  endtask

  initial begin
    logic [31:0] snap;
    bit          stable, no_stb;

    reset = 1'b1; set_stb = 1'b0; set_addr = '0; set_data = '0;
    spi_ready = 1'b1; spi_readback = '0; rb_ready = 1'b1;

    vecs[0] = '{16'h0002, 32'h0800_0001, 32'hA500_0000, 1,  32'h5AFF_FFFF};
    vecs[1] = '{16'hFFFF, 32'hFFFF_FFFF, 32'h0000_0000, 5,  32'hFFFF_FFFF};
    vecs[2] = '{16'h0010, 32'h2000_0002, 32'h1234_5678, 2,  32'hEDCB_A987};
    vecs[3] = '{16'h0001, 32'h4000_0004, 32'hFFFF_FFFF, 12, 32'h0000_0000};

    @(negedge clock);
    repeat (3) tick();
    check("rst_rb_valid", {63'h0, rb_valid}, 64'h0);
    check("rst_rb_data", {32'h0, rb_data}, 64'h0);
    check("rst_spi_stb", {63'h0, spi_set_stb}, 64'h0);
    check("rst_spi_addr", {56'h0, spi_set_addr}, 64'h0);
    check("rst_spi_data", {32'h0, spi_set_data}, 64'h0);
    check("rst_cmd_count", {59'h0, cmd_count}, 64'h0);
    check("rst_overflow", {63'h0, overflow}, 64'h0);
    check("rst_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      core_lat = vecs[i].lat;
      wr_div(vecs[i].div);
      wr_cfg(vecs[i].cfg);
      push(vecs[i].data, 1'b1, vecs[i].rb);
      if (i == 0) begin
        check("count_after_push", {59'h0, cmd_count}, 64'h1);
        check("no_stb_before_pop", {63'h0, spi_set_stb}, 64'h0);
        tick();
        check("pop_to_stb_latency", {63'h0, spi_set_stb}, 64'h1);
        check("count_after_pop", {59'h0, cmd_count}, 64'h0);
      end
      wait_drain(200);
      check("vec_idle_busy", {63'h0, busy}, 64'h0);
    end

    // Burst of four back-to-back pushes with the consumer always ready.
    core_lat = 3;
    wr_div(16'h0007);
    wr_cfg(32'h0800_0003);
    for (int k = 0; k < 4; k++) push(32'hC0DE_0000 + 32'(k), 1'b1, ~(32'hC0DE_0000 + 32'(k)));
    check("burst_count", {59'h0, cmd_count}, 64'h3);
    wait_drain(300);
    check("burst_count_end", {59'h0, cmd_count}, 64'h0);

    // Backpressure: an unconsumed readback must hold the queue.
    rb_ready = 1'b0;
    core_lat = 2;
    push(32'h1111_0000, 1'b1, 32'hEEEE_FFFF);
    push(32'h2222_0000, 1'b1, 32'hDDDD_FFFF);
    wait_rb_valid(100);
    snap   = rb_data;
    stable = 1'b1;
    no_stb = 1'b1;
    repeat (20) begin
      tick();
      if (rb_data !== snap) stable = 1'b0;
      if (spi_set_stb) no_stb = 1'b0;
    end
    check("bp_rb_value", {32'h0, snap}, 64'hEEEE_FFFF);
    check("bp_rb_stable", {63'h0, stable}, 64'h1);
    check("bp_no_stb", {63'h0, no_stb}, 64'h1);
    check("bp_count", {59'h0, cmd_count}, 64'h1);
    rb_ready = 1'b1;
    wait_drain(200);

    // Overflow: 17 pushes while stalled, the last one must be dropped.
    rb_ready = 1'b0;
    push(32'h3333_0000, 1'b1, 32'hCCCC_FFFF);
    wait_rb_valid(100);
    for (int k = 0; k < 17; k++) push(32'h4000_0000 + 32'(k), k < 16, ~(32'h4000_0000 + 32'(k)));
    check("ovf_count_full", {59'h0, cmd_count}, 64'h10);
    check("ovf_set", {63'h0, overflow}, 64'h1);
    host_write(8'(Base + 3), 32'h0);
    check("ovf_cleared", {63'h0, overflow}, 64'h0);
    check("ovf_count_kept", {59'h0, cmd_count}, 64'h10);
    rb_ready = 1'b1;
    wait_drain(1000);
    repeat (20) tick();
    check("ovf_drained_busy", {63'h0, busy}, 64'h0);

    // Push and pop in the same cycle at count 1.
    rb_ready = 1'b0;
    push(32'h5555_0000, 1'b1, 32'hAAAA_FFFF);
    wait_rb_valid(100);
    push(32'h6666_0000, 1'b1, 32'h9999_FFFF);
    check("pp_count_before", {59'h0, cmd_count}, 64'h1);
    rb_ready = 1'b1;
    tick();
    push(32'h7777_0000, 1'b1, 32'h8888_FFFF);
    check("pp_count_same", {59'h0, cmd_count}, 64'h1);
    wait_drain(200);

    // Reset while waiting on the core aborts the transaction and empties the queue.
    core_lat = 30;
    wr_div(16'h0055);
    wr_cfg(32'h0100_0000);
    push(32'h8888_0000, 1'b1, 32'h7777_FFFF);
    begin
      int n = 0;
      while (exp_stb.size() != 0 && n < 50) begin
        tick();
        n++;
      end
      if (exp_stb.size() != 0) fail("strobes_timeout_pending", exp_stb.size(), 0);
    end
    repeat (3) tick();
    push(32'h9999_0000, 1'b0, 32'h0);
    check("pre_rst_count", {59'h0, cmd_count}, 64'h1);
    check("pre_rst_rb_valid", {63'h0, rb_valid}, 64'h0);
    reset = 1'b1;
    spi_ready = 1'b1;
    core_cnt = 0;
    inflight = 1'b0;
    exp_stb.delete();
    exp_rb.delete();
    m_div = '0;
    m_cfg = '0;
    tick();
    check("mid_rst_count", {59'h0, cmd_count}, 64'h0);
    check("mid_rst_rb_valid", {63'h0, rb_valid}, 64'h0);
    check("mid_rst_stb", {63'h0, spi_set_stb}, 64'h0);
    check("mid_rst_busy", {63'h0, busy}, 64'h0);
    reset = 1'b0;
    repeat (10) tick();
    core_lat = 2;
    push(32'hABCD_0000, 1'b1, 32'h5432_FFFF);
    wait_drain(200);
    check("final_busy", {63'h0, busy}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
